// File: rtl/seq_gen.sv
// Serial pattern generator: IDLE/SHIFT/DONE FSM, MSB-first bit on each cycle after start, start-to-start >= WIDTH+2.
// No backpressure (start is dropped while busy); SEQ_GEN_REPEAT_EN adds the rpt input for gapless repeats.
module seq_gen #(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] PATTERN = 5'b10101
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             use_ext,
   input  logic [WIDTH-1:0] pat_in,
`ifdef SEQ_GEN_REPEAT_EN
   // "repeat" is a reserved word in SystemVerilog, hence rpt
   input  logic             rpt,
`endif
   output logic             outbit,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [7:0]       sent_cnt
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] sel_pat;
   logic             reload;

   assign sel_pat = use_ext ? pat_in : PATTERN;

`ifdef SEQ_GEN_REPEAT_EN
   assign reload = rpt;
`else
   assign reload = 1'b0;
`endif

   // The register rotates rather than shifts so that after WIDTH steps it holds the
   // original pattern again, which is what a repeat reloads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         outbit    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sent_cnt  <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg     <= sel_pat;
                  outbit    <= sel_pat[WIDTH-1];
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  bit_cnt   <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               shreg <= {shreg[WIDTH-2:0], shreg[WIDTH-1]};
               if (bit_cnt == LAST) begin
                  sent_cnt <= sent_cnt + 8'd1;
                  bit_cnt  <= '0;
                  if (reload) begin
                     outbit <= shreg[WIDTH-2];
                  end else begin
                     outbit    <= 1'b0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
                  outbit  <= shreg[WIDTH-2];
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               outbit    <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: stimulus queues expected bits/done pulses, a negedge monitor checks them.
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       use_ext = 1'b0;
   logic [4:0] pat_in = 5'd0;
   logic       outbit, out_valid, busy, done;
   logic [7:0] sent_cnt;
`ifdef SEQ_GEN_REPEAT_EN
   logic       rpt = 1'b0;
`endif

   seq_gen #(.WIDTH(5), .PATTERN(5'b10101)) dut (
      .clk(clk), .rst(rst), .start(start), .use_ext(use_ext), .pat_in(pat_in),
`ifdef SEQ_GEN_REPEAT_EN
      .rpt(rpt),
`endif
      .outbit(outbit), .out_valid(out_valid), .busy(busy), .done(done), .sent_cnt(sent_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_done;
      bit         b;
      logic [7:0] cnt;
      int         len;
   } exp_t;

   exp_t       q[$];
   int         stamps[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [7:0] exp_cnt = 8'd0;
   int         exp_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_pattern(input logic [4:0] p, input bit with_done);
      exp_t e;
      for (int i = 4; i >= 0; i--) begin
         e.is_done = 1'b0; e.b = p[i]; e.cnt = exp_cnt; e.len = 0;
         q.push_back(e);
      end
      exp_cnt = exp_cnt + 8'd1;
      exp_run += 5;
      if (with_done) begin
         e.is_done = 1'b1; e.b = 1'b0; e.cnt = exp_cnt; e.len = exp_run;
         q.push_back(e);
         exp_run = 0;
      end
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (q.size() == 0) break;
         @(negedge clk); #2;
      end
      check("scoreboard_drained", q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outbit"}, outbit, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_sent_cnt"}, sent_cnt, 0);
   endtask

   // Monitor: consumes one expected entry per valid bit or done pulse.
   int run = 0;
   bit prev_v = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         run = 0;
         prev_v = 1'b0;
      end else begin
         check("busy_eq_valid", busy, out_valid);
         if (out_valid) begin
            if (!prev_v) stamps.push_back(cyc);
            run++;
            check("done_low_while_valid", done, 0);
            if (q.size() == 0) check("unexpected_bit", 1, 0);
            else begin
               e = q.pop_front();
               check("kind_bit", e.is_done, 0);
               check("outbit", outbit, e.b);
               check("cnt_during_bits", sent_cnt, e.cnt);
            end
         end else begin
            check("outbit_zero_when_invalid", outbit, 0);
            if (done) begin
               if (q.size() == 0) check("unexpected_done", 1, 0);
               else begin
                  e = q.pop_front();
                  check("kind_done", e.is_done, 1);
                  check("cnt_at_done", sent_cnt, e.cnt);
                  check("valid_run_len", run, e.len);
               end
               run = 0;
            end
         end
         prev_v = out_valid;
      end
   end

   initial begin
      // reset state, asserted from time zero
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // built-in pattern
      push_pattern(5'b10101, 1'b1);
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      wait_drain(20);
      check("cnt_after_first", sent_cnt, 1);

      // external pattern, inputs change after the start edge
      @(negedge clk);
      push_pattern(5'b11001, 1'b1);
      use_ext = 1'b1; pat_in = 5'b11001; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 pat_in = 5'b00000; use_ext = 1'b0;
      wait_drain(20);

      // start held for 20 cycles: exactly three patterns, 7 cycles apart
      @(negedge clk);
      stamps.delete();
      for (int k = 0; k < 3; k++) push_pattern(5'b10101, 1'b1);
      start = 1'b1;
      repeat (20) @(posedge clk);
      #1 start = 1'b0;
      wait_drain(30);
      check("held_start_patterns", stamps.size(), 3);
      if (stamps.size() == 3) begin
         check("period_1", stamps[1] - stamps[0], 7);
         check("period_2", stamps[2] - stamps[1], 7);
      end

`ifdef SEQ_GEN_REPEAT_EN
      // repeat: three gapless patterns, single done after rpt drops
      @(negedge clk);
      push_pattern(5'b10101, 1'b0);
      push_pattern(5'b10101, 1'b0);
      push_pattern(5'b10101, 1'b1);
      rpt = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rpt = 1'b0;
      wait_drain(30);
`endif

      // fresh reset, then abort during the third bit
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1; exp_cnt = 8'd0; exp_run = 0;
      @(negedge clk);
      begin
         exp_t e;
         for (int i = 0; i < 3; i++) begin
            e.is_done = 1'b0; e.b = (i != 1); e.cnt = 8'd0; e.len = 0;
            q.push_back(e);
         end
      end
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      check("abort_bits_seen", q.size(), 0);
      rst = 1'b0;
      #1 check_all_zero("async_abort");
      repeat (3) @(negedge clk);
      // start already high when reset releases is honoured at the very next edge
      push_pattern(5'b10101, 1'b1);
      start = 1'b1; rst = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("first_edge_valid", out_valid, 1);
      check("first_edge_outbit", outbit, 1);
      wait_drain(20);
      check("cnt_after_abort", sent_cnt, 1);

      // counter wrap: 257 back-to-back patterns from zero
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1; exp_cnt = 8'd0; exp_run = 0;
      @(negedge clk);
      for (int k = 0; k < 257; k++) push_pattern(5'b10101, 1'b1);
      start = 1'b1;
      repeat (7 * 256 + 1) @(posedge clk);
      #1 start = 1'b0;
      wait_drain(2000);
      check("cnt_after_wrap", sent_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
